// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, credit-limited imem requests, in-order response buffer, branch redirect.
// Request->if_valid is 2+ cycles; requests stall once in-flight plus buffered words reach FIFO_DEPTH.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken_ex,
  input  logic [31:0] calculated_adr,
  input  logic        dec_ready,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_if,
  output logic [31:0] pc_plus_4_if
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_W = FIFO_DEPTH[CW:0];

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } ifq_t;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  ifq_t          fifo_mem [FIFO_DEPTH];
  ifq_t          head_dat;
  ifq_t          push_dat;
  logic [31:0]   target;
  logic          req_fire;
  logic          rsp_acc;
  logic          do_push;
  logic          do_pop;

  assign target      = calculated_adr & 32'hFFFF_FFFC;
  assign credit_used = {1'b0, outstanding} + {1'b0, count};

  // Buffered words count against the credit so every accepted response has a free slot.
  assign imem_req_valid = rst && !branch_taken_ex && (credit_used < DEPTH_W);
  assign imem_addr      = fetch_pc;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_acc  = imem_rsp_valid && (outstanding != '0);
  assign do_push  = rsp_acc && (drop_cnt == '0) && !branch_taken_ex;
  assign do_pop   = if_valid && dec_ready && !branch_taken_ex;
  assign push_dat = '{word: imem_rsp_data, pc: resp_pc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_acc);
      if (branch_taken_ex) begin
        fetch_pc <= target;
        resp_pc  <= target;
        // Everything still in flight belongs to the old path and must be discarded on return.
        drop_cnt <= outstanding - CW'(rsp_acc);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (do_push) resp_pc <= resp_pc + 32'd4;
        else if (rsp_acc) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (branch_taken_ex) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= push_dat;
  end

  assign head_dat     = fifo_mem[rd_ptr];
  assign if_valid     = (count != '0);
  assign instruction  = if_valid ? head_dat.word : 32'h0000_0013;
  assign pc_if        = if_valid ? head_dat.pc : 32'h0;
  assign pc_plus_4_if = if_valid ? (head_dat.pc + 32'd4) : 32'h0;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: behavioural imem with per-phase latency, queues of expected requests/outputs.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        branch_taken_ex = 1'b0;
  logic [31:0] calculated_adr = 32'h0;
  logic        dec_ready = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        if_valid;
  logic [31:0] instruction;
  logic [31:0] pc_if;
  logic [31:0] pc_plus_4_if;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .branch_taken_ex(branch_taken_ex),
    .calculated_adr (calculated_adr),
    .dec_ready      (dec_ready),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .instruction    (instruction),
    .pc_if          (pc_if),
    .pc_plus_4_if   (pc_plus_4_if)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pending[$];
  logic [31:0] req_q[$];
  logic [31:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int budget = 0;
  int lat = 1;
  bit stray = 1'b0;
  int first_req_cyc = -1;
  int first_vld_cyc = -1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // Memory: accepts while budget remains, answers in order after 'lat' cycles.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    imem_req_ready = (budget > 0);
    if (stray) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end else if (pending.size() > 0 && pending[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pending[0].addr);
      void'(pending.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  // Monitor: requests and accepted outputs are checked against the expected queues.
  always @(negedge clk) begin
    if (rst && imem_req_valid && imem_req_ready) begin
      pending.push_back('{addr: imem_addr, due: cyc + lat});
      budget--;
      if (first_req_cyc < 0) first_req_cyc = cyc;
      if (req_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL req_extra: got addr %h want no request", imem_addr);
      end else begin
        check("req_addr", imem_addr, req_q.pop_front());
      end
    end
    if (if_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (if_valid && dec_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_extra: got pc %h want no output", pc_if);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("out_pc", pc_if, e);
        check("out_pc4", pc_plus_4_if, e + 32'd4);
        check("out_instr", instruction, mem_word(e));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((req_q.size() != 0 || exp_q.size() != 0) && n < 200) begin
      step(1);
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL %s_drain: got %0d reqs %0d outs left want 0", name, req_q.size(), exp_q.size());
      req_q.delete();
      exp_q.delete();
    end
  endtask

  task automatic wait_budget(input string name);
    int n = 0;
    while (budget > 0 && n < 50) begin
      step(1);
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL %s_issue: got %0d requests pending want 0", name, budget);
      budget = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    step(3);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_instr", instruction, 32'h0000_0013);
    check("rst_pc", pc_if, 32'h0);
    check("rst_pc4", pc_plus_4_if, 32'h0);

    // Stream from RESET_PC with 1-cycle memory.
    req_q = '{32'h0, 32'h4, 32'h8};
    exp_q = '{32'h0, 32'h4, 32'h8};
    dec_ready = 1'b1;
    budget = 3;
    rst = 1'b1;
    wait_drain("stream");
    check("first_latency", 32'(first_vld_cyc - first_req_cyc), 32'd2);
    step(2);

    // Decode stall: exactly two requests, head holds.
    dec_ready = 1'b0;
    budget = 6;
    req_q = '{32'hC, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20};
    exp_q = '{32'hC, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20};
    step(10);
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_if_valid", 32'(if_valid), 32'd1);
    check("stall_pc", pc_if, 32'hC);
    check("stall_reqs_left", 32'(req_q.size()), 32'd4);
    step(3);
    check("stall_instr", instruction, mem_word(32'hC));
    dec_ready = 1'b1;
    wait_drain("stall");
    step(2);

    // Redirect with two in flight, 3-cycle memory.
    lat = 3;
    dec_ready = 1'b0;
    budget = 2;
    req_q = '{32'h24, 32'h28};
    wait_budget("redir2");
    branch_taken_ex = 1'b1;
    calculated_adr = 32'h103;
    #1;
    check("redir2_req_valid", 32'(imem_req_valid), 32'd0);
    step(1);
    branch_taken_ex = 1'b0;
    budget = 2;
    req_q = '{32'h100, 32'h104};
    exp_q = '{32'h100, 32'h104};
    dec_ready = 1'b1;
    wait_drain("redir2");
    step(2);

    // Response coincides with redirect, 2-cycle memory.
    lat = 2;
    dec_ready = 1'b0;
    budget = 2;
    req_q = '{32'h108, 32'h10C};
    wait_budget("redir_rsp");
    branch_taken_ex = 1'b1;
    calculated_adr = 32'h200;
    step(1);
    branch_taken_ex = 1'b0;
    budget = 2;
    req_q = '{32'h200, 32'h204};
    exp_q = '{32'h200, 32'h204};
    dec_ready = 1'b1;
    wait_drain("redir_rsp");
    step(2);

    // Redirect while idle, address wrap.
    lat = 1;
    step(2);
    branch_taken_ex = 1'b1;
    calculated_adr = 32'hFFFF_FFFC;
    #1;
    check("idle_redir_req_valid", 32'(imem_req_valid), 32'd0);
    step(1);
    branch_taken_ex = 1'b0;
    #1;
    check("wrap_req_valid", 32'(imem_req_valid), 32'd1);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    budget = 2;
    req_q = '{32'hFFFF_FFFC, 32'h0};
    exp_q = '{32'hFFFF_FFFC, 32'h0};
    wait_drain("wrap");
    step(2);

    // Asynchronous reset mid-stream, then a stray response.
    dec_ready = 1'b0;
    budget = 2;
    req_q = '{32'h4, 32'h8};
    wait_budget("areset");
    step(3);
    check("pre_rst_if_valid", 32'(if_valid), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("arst_if_valid", 32'(if_valid), 32'd0);
    check("arst_instr", instruction, 32'h0000_0013);
    check("arst_req_valid", 32'(imem_req_valid), 32'd0);
    check("arst_pc", pc_if, 32'h0);
    pending.delete();
    step(2);
    rst = 1'b1;
    stray = 1'b1;
    step(1);
    stray = 1'b0;
    check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("post_rst_addr", imem_addr, 32'h0);
    step(2);
    check("stray_if_valid", 32'(if_valid), 32'd0);
    budget = 2;
    req_q = '{32'h0, 32'h4};
    exp_q = '{32'h0, 32'h4};
    dec_ready = 1'b1;
    wait_drain("post_rst");
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
